// File: rtl/iter_divider.sv
// iter_divider: iterative 32-bit radix-2 restoring divider for the MDU DIV/DIVU path.
// One quotient bit per clock, fixed 33-cycle latency from the start edge to ready_o.
// Handshake: start_i is a single-cycle request, accepted only in IDLE or DONE;
// ready_o is a level that stays high from completion until the next accepted start.
// busy_o covers CALC and FIX, so ready_o and busy_o are never high together.
module iter_divider (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  input  logic        start_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_abs_q, div_abs_d;
  logic [31:0] raw_a_q, raw_a_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  // Operand preparation: signs only count in signed mode. Negating 0x80000000
  // yields 0x80000000, which is exactly the right magnitude read as unsigned.
  logic        a_neg_in, b_neg_in;
  logic [31:0] a_abs_in, b_abs_in;

  // One restoring step: the remainder shifted left picks up the next dividend
  // bit. The shifted value can need 33 bits, so the trial keeps the extra bit.
  logic [32:0] part;
  logic [32:0] trial;

  // Final sign fix-up: quotient sign is the XOR of operand signs, remainder
  // follows the dividend (truncating division).
  logic [31:0] quo_fixed, rem_fixed;

  // Operand sign/magnitude and the per-iteration trial subtraction.
  always_comb begin
    a_neg_in  = signed_i & dividend_i[31];
    b_neg_in  = signed_i & divisor_i[31];
    a_abs_in  = a_neg_in ? (32'd0 - dividend_i) : dividend_i;
    b_abs_in  = b_neg_in ? (32'd0 - divisor_i) : divisor_i;
    part      = {rem_q, quo_q[31]};
    trial     = part - {1'b0, div_abs_q};
    quo_fixed = (a_neg_q ^ b_neg_q) ? (32'd0 - quo_q) : quo_q;
    rem_fixed = a_neg_q ? (32'd0 - rem_q) : rem_q;
  end

  // Next-state and datapath control; every register defaults to holding.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_abs_d   = div_abs_q;
    raw_a_d     = raw_a_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = ready_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_CALC;
          cnt_d      = 6'd0;
          rem_d      = 32'd0;
          quo_d      = a_abs_in;
          div_abs_d  = b_abs_in;
          raw_a_d    = dividend_i;
          a_neg_d    = a_neg_in;
          b_neg_d    = b_neg_in;
          div_zero_d = (divisor_i == 32'd0);
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_CALC: begin
        rem_d = trial[32] ? part[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div_zero_q) begin
          quotient_d  = 32'hFFFF_FFFF;
          remainder_d = raw_a_q;
        end else begin
          quotient_d  = quo_fixed;
          remainder_d = rem_fixed;
        end
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any divide in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      div_abs_q   <= 32'd0;
      raw_a_q     <= 32'd0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_abs_q   <= div_abs_d;
      raw_a_q     <= raw_a_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and random divides against a latency/arithmetic model.
module tb_iter_divider;

  logic        clk;
  logic        rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_in;
  logic        start;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  iter_divider dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .signed_i    (signed_in),
    .start_i     (start),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .ready_o     (ready),
    .busy_o      (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference arithmetic: truncating division, zero divisor -> all ones / dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa;
    int sb;
    int sq;
    int sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sq, sr};
  endfunction

  // Model: a start while not busy launches a divide whose result appears 33
  // clocks later; starts while busy are dropped.
  logic [31:0] m_q, m_r, p_q, p_r;
  logic        m_ready, m_busy;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= 32'd0; m_r <= 32'd0; p_q <= 32'd0; p_r <= 32'd0;
      m_ready <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else if (!m_busy && start) begin
      {p_q, p_r} <= ref_div(dividend, divisor, signed_in);
      m_busy  <= 1'b1;
      m_ready <= 1'b0;
      m_cnt   <= 33;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_q     <= p_q;
        m_r     <= p_r;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Scoreboard compare every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_quotient", quotient, m_q);
      chk("cyc_remainder", remainder, m_r);
      chk("cyc_ready", {31'd0, ready}, {31'd0, m_ready});
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    end
  end

  // Driver tasks
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input string nm);
    int n;
    dividend  = a;
    divisor   = b;
    signed_in = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({nm, "_ready_after_start"}, {31'd0, ready}, 32'd0);
    wait_ready(n);
    chk({nm, "_latency"}, n, 32'd33);
    chk({nm, "_quotient"}, quotient, eq);
    chk({nm, "_remainder"}, remainder, er);
    chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [63:0] pin;
    rst = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0; signed_in = 1'b0;

    // Model pins against hand-computed values
    pin = ref_div(32'd100, 32'd7, 1'b0);
    chk("model_100_7", pin[63:32], 32'd14);
    pin = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("model_m7_2_rem", pin[31:0], 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "s_7_m2");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, "u_big_2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "s_ovf");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "u_min_max");
    do_div(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, "u_div0");
    do_div(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, "s_div0");
    do_div(32'hFFFF_EDCC, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_EDCC, "s_neg_div0");

    // Start ignored mid-divide, then restart on the cycle ready rises
    dividend = 32'd100; divisor = 32'd7; signed_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    wait_ready(n);
    chk("ignore_latency", n + 10, 32'd33);
    chk("ignore_quotient", quotient, 32'd14);
    chk("ignore_remainder", remainder, 32'd2);
    do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "restart_9_3");

    // Asynchronous reset in the middle of a divide
    dividend = 32'd100; divisor = 32'd7; signed_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #3 rst = 1'b1;
    #1;
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_remainder", remainder, 32'd0);
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    do_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "u50_5");

    // Random operands, checked by the per-cycle scoreboard
    for (int i = 0; i < 150; i++) begin
      dividend  = $urandom;
      signed_in = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: divisor = 32'd0;
        1: divisor = 32'($urandom_range(1, 20));
        2: divisor = 32'hFFFF_FFFF;
        3: begin divisor = $urandom; dividend = 32'h8000_0000; end
        default: divisor = $urandom;
      endcase
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_ready(n);
      chk("rand_latency", n, 32'd33);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
